// File: rtl/final_soc_pio_read_arbiter.sv
// rtl/final_soc_pio_read_arbiter.sv - round-robin read arbiter for a shared Avalon-MM PIO slave
// One read in flight: grant in IDLE, address phase, data capture, then a one-hot response pulse.
module final_soc_pio_read_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int ADDR_W    = 2,
  parameter int DATA_W    = 32,
  parameter int IDLE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [ADDR_W-1:0]         slv_address,
  input  logic [DATA_W-1:0]         slv_readdata,
  output logic                      busy
);

  localparam int                GW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] IDLE_A = ADDR_W'(IDLE_ADDR);
  localparam logic [GW-1:0]     LAST   = GW'(NUM_REQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t                    state, state_next;
  logic [GW-1:0]             last_grant, owner, winner;
  logic                      found;
  int                        idx;
  logic [NUM_REQ-1:0]        valid_sh;
  logic [NUM_REQ*ADDR_W-1:0] addr_sh;
  logic [ADDR_W-1:0]         winner_addr;

  // Search starts just after the previous winner and wraps, so every requester gets a turn.
  always_comb begin
    found    = 1'b0;
    winner   = last_grant;
    idx      = 0;
    valid_sh = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx      = (int'(last_grant) + k) % NUM_REQ;
      valid_sh = req_valid >> idx;
      if (!found && valid_sh[0]) begin
        found  = 1'b1;
        winner = GW'(idx);
      end
    end
    addr_sh     = req_address >> (int'(winner) * ADDR_W);
    winner_addr = addr_sh[ADDR_W-1:0];
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    case (state)
      S_IDLE: begin
        if (found) begin
          req_ready  = NUM_REQ'(1) << winner;
          state_next = S_ADDR;
        end
      end
      S_ADDR:  state_next = S_DATA;
      S_DATA:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      slv_address <= IDLE_A;
      rsp_data    <= '0;
      rsp_valid   <= '0;
      busy        <= 1'b0;
      last_grant  <= LAST;
      owner       <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            slv_address <= winner_addr;
            owner       <= winner;
            last_grant  <= winner;
            busy        <= 1'b1;
          end
        end
        S_ADDR: slv_address <= IDLE_A;
        S_DATA: begin
          rsp_data  <= slv_readdata;
          rsp_valid <= NUM_REQ'(1) << owner;
          busy      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_final_soc_pio_read_arbiter.sv
// tb/tb_final_soc_pio_read_arbiter.sv - self-checking bench for final_soc_pio_read_arbiter
// Four requesters sharing a modelled registered-readdata PIO slave.
module tb_final_soc_pio_read_arbiter;

  localparam int            N      = 4;
  localparam int            AW     = 2;
  localparam int            DW     = 32;
  localparam logic [AW-1:0] IDLE_A = 2'd2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_address = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic [AW-1:0]   slv_address;
  logic [DW-1:0]   slv_readdata = '0;
  logic            busy;
  logic [31:0]     in_port = '0;

  int n_pass = 0;
  int n_total = 0;

  final_soc_pio_read_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDLE_ADDR(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_address(req_address),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .slv_address(slv_address), .slv_readdata(slv_readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] slave_fn(input logic [1:0] a, input logic [31:0] p);
    case (a)
      2'd0:    return p;
      2'd1:    return 32'h0;
      2'd2:    return 32'hCAFE_0002;
      default: return 32'h5EED_0003;
    endcase
  endfunction

  always @(posedge clk) slv_readdata <= slave_fn(slv_address, in_port);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  typedef struct {
    logic [N-1:0] who;
    logic [31:0]  data;
  } rsp_t;

  rsp_t       sb[$];
  int         m_phase = 0;
  logic [1:0] m_lg = 2'd3;
  logic [1:0] m_addr = '0;
  bit         m_pend = 1'b0;

  // Cycle-level reference: predicts grants, address phases and the response pulse.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    logic [1:0]   w, c;
    bit           f;
    rsp_t         e;
    if (!reset_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_slv_address", 32'(slv_address), 32'(IDLE_A));
      chk("rst_rsp_data", rsp_data, 32'h0);
      m_phase = 0;
      m_lg    = 2'd3;
      m_pend  = 1'b0;
      sb.delete();
    end else begin
      if (m_pend) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_underflow: no expected response queued");
        end else begin
          e = sb.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(e.who));
          chk("rsp_data", rsp_data, e.data);
        end
      end else begin
        chk("rsp_valid_quiet", 32'(rsp_valid), 32'h0);
      end
      m_pend = 1'b0;
      case (m_phase)
        0: begin
          f = 1'b0;
          w = '0;
          exp_ready = '0;
          for (int k = 1; k <= N; k++) begin
            c = m_lg + 2'(k);
            if (!f && req_valid[c]) begin
              f = 1'b1;
              w = c;
            end
          end
          if (f) exp_ready[w] = 1'b1;
          chk("req_ready", 32'(req_ready), 32'(exp_ready));
          chk("busy_idle", 32'(busy), 32'h0);
          chk("slv_addr_idle", 32'(slv_address), 32'(IDLE_A));
          if (f) begin
            m_addr = req_address[w*AW +: AW];
            e.who  = exp_ready;
            e.data = slave_fn(m_addr, in_port);
            sb.push_back(e);
            m_lg    = w;
            m_phase = 1;
          end
        end
        1: begin
          chk("slv_addr_phase", 32'(slv_address), 32'(m_addr));
          chk("busy_addr", 32'(busy), 32'h1);
          chk("ready_addr", 32'(req_ready), 32'h0);
          m_phase = 2;
        end
        default: begin
          chk("slv_addr_data", 32'(slv_address), 32'(IDLE_A));
          chk("busy_data", 32'(busy), 32'h1);
          chk("ready_data", 32'(req_ready), 32'h0);
          m_phase = 0;
          m_pend  = 1'b1;
        end
      endcase
    end
  end

  typedef struct {
    int          req;
    logic [1:0]  addr;
    logic [31:0] in_port;
    logic [31:0] exp_data;
  } vec_t;

  vec_t tbl[6];

  task automatic wait_grant(input string name, output logic [N-1:0] g, output int cyc);
    g   = '0;
    cyc = 0;
    for (int i = 0; i < 20 && g == '0; i++) begin
      @(negedge clk);
      cyc = i + 1;
      g   = req_ready;
    end
    if (g == '0) begin
      n_total++;
      $display("FAIL %s: no grant within 20 cycles", name);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    logic [N-1:0] g;
    int           cyc;
    bit           seen;
    tbl[0] = '{0, 2'd0, 32'h0000_0001, 32'h0000_0001};
    tbl[1] = '{1, 2'd1, 32'h0000_0001, 32'h0000_0000};
    tbl[2] = '{1, 2'd0, 32'h0000_0001, 32'h0000_0001};
    tbl[3] = '{2, 2'd3, 32'h0000_0000, 32'h5EED_0003};
    tbl[4] = '{3, 2'd0, 32'h8000_0000, 32'h8000_0000};
    tbl[5] = '{0, 2'd2, 32'h0000_0005, 32'hCAFE_0002};

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      in_port = tbl[i].in_port;
      req_address[tbl[i].req*AW +: AW] = tbl[i].addr;
      req_valid[tbl[i].req] = 1'b1;
      wait_grant("tbl_grant", g, cyc);
      chk("tbl_grant", 32'(g), 32'(4'b0001 << tbl[i].req));
      chk("tbl_grant_latency", 32'(cyc), 32'd1);
      @(posedge clk);
      #1 req_valid = '0;
      @(negedge clk);
      chk("tbl_slv_addr", 32'(slv_address), 32'(tbl[i].addr));
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("tbl_rsp_valid", 32'(rsp_valid), 32'(4'b0001 << tbl[i].req));
      chk("tbl_rsp_data", rsp_data, tbl[i].exp_data);
      @(posedge clk);
      #1;
    end

    // Two requesters held high alternate from reset, starting with requester 0.
    do_reset();
    req_address = {2'd3, 2'd2, 2'd1, 2'd0};
    in_port     = 32'h0000_00A5;
    req_valid   = 4'b0011;
    for (int i = 0; i < 4; i++) begin
      wait_grant("rr_grant", g, cyc);
      chk("rr_grant", 32'(g), (i % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_spacing", 32'(cyc), (i == 0) ? 32'd1 : 32'd3);
    end
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // Last grant was requester 1: requester 3 wins before wrapping to 0.
    req_valid = 4'b1001;
    wait_grant("wrap_first", g, cyc);
    chk("wrap_first", 32'(g), 32'h8);
    @(posedge clk);
    #1 req_valid[3] = 1'b0;
    wait_grant("wrap_second", g, cyc);
    chk("wrap_second", 32'(g), 32'h1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Reset during the data phase drops the read; priority returns to requester 0.
    do_reset();
    req_valid = 4'b0010;
    wait_grant("rst_pre_grant", g, cyc);
    @(posedge clk);
    #1 req_valid = '0;
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("rst_mid_busy", 32'(busy), 32'h0);
    chk("rst_mid_rsp_valid", 32'(rsp_valid), 32'h0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    req_valid = 4'b0011;
    wait_grant("rst_post_grant", g, cyc);
    chk("rst_post_grant", 32'(g), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(posedge clk);
    #1;

    // A pulse that comes and goes during another transaction is never granted.
    req_address[3:2] = 2'd1;
    in_port   = 32'h0000_0001;
    req_valid = 4'b0010;
    wait_grant("wd_owner", g, cyc);
    chk("wd_owner", 32'(g), 32'h2);
    @(posedge clk);
    #1 req_valid = 4'b0100;
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (req_ready[2] || rsp_valid[2]) seen = 1'b1;
      if (rsp_valid[1]) chk("wd_owner_data", rsp_data, 32'h0);
    end
    chk("wd_no_grant", 32'(seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
